// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster engine: default 640x480@60 timing,
// the packed RGB type and the colour-bar palette used by the test pattern.
package vga_pkg;

  // Default 640x480@60 mode (25 MHz pixel clock from a 50 MHz system clock).
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CLK_DIV_DEF  = 2;
  localparam int LATENCY_DEF  = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Colour bars, left to right.
  localparam rgb_t BAR_WHITE   = rgb_t'(24'hFFFFFF);
  localparam rgb_t BAR_YELLOW  = rgb_t'(24'hFFFF00);
  localparam rgb_t BAR_CYAN    = rgb_t'(24'h00FFFF);
  localparam rgb_t BAR_GREEN   = rgb_t'(24'h00FF00);
  localparam rgb_t BAR_MAGENTA = rgb_t'(24'hFF00FF);
  localparam rgb_t BAR_RED     = rgb_t'(24'hFF0000);
  localparam rgb_t BAR_BLUE    = rgb_t'(24'h0000FF);
  localparam rgb_t BAR_BLACK   = rgb_t'(24'h000000);

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of DEPTH stages; q is data from DEPTH
// enabled cycles ago. Clears to zero on reset.
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("vga_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine. Divides CLOCK_50 down to a pixel tick, scans h/v
// counters over the configured mode, issues (x,y) requests LATENCY ticks
// ahead of display, and registers sync/blank/RGB onto the DAC pins so the
// returned pixel data lines up with its own sync/blank.
// Optional build macro VGA_TEST_PATTERN_EN adds an 8-bar colour pattern
// selected by test_mode; without it test_mode is ignored.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int LATENCY  = LATENCY_DEF
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  output logic                        req_valid,
  output logic [$clog2(H_ACTIVE)-1:0] req_x,
  output logic [$clog2(V_ACTIVE)-1:0] req_y,
  output logic                        pix_ce,
  output logic                        frame_start,
  input  logic [23:0]                 rgb_in,
  input  logic                        test_mode,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic                        VGA_BLANK_N,
  output logic                        VGA_SYNC_N,
  output logic                        VGA_CLK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be even and at least 2");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: every porch and sync width must be at least 1");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("vga_timing_gen: LATENCY must be in 1..8");
  end
  if (H_ACTIVE < 2 || V_ACTIVE < 2) begin : g_bad_active
    $error("vga_timing_gen: active area must be at least 2x2");
  end

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          run;
  logic          active;
  logic          hs_act;
  logic          vs_act;
  logic [2:0]    ctl_d;
  logic          act_d;
  logic          hs_d;
  logic          vs_d;
  rgb_t          pix_src;

  assign pix_ce  = (div_cnt == DIV_LAST);
  assign div_nxt = pix_ce ? '0 : div_cnt + 1'b1;

  // Pixel divider; VGA_CLK is low for the first half of each pixel so the
  // DAC latches on a rising edge in the middle of stable data.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      div_cnt <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      VGA_CLK <= (div_nxt >= DIV_HALF);
    end
  end

  // Raster counters; run masks req_valid while the counters sit in reset.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (pix_ce) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_act      = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vs_act      = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
  assign req_valid   = active && run;
  assign req_x       = h_cnt[XW-1:0];
  assign req_y       = v_cnt[YW-1:0];
  assign frame_start = pix_ce && (h_cnt == '0) && (v_cnt == '0);
  assign VGA_SYNC_N  = 1'b1;

  vga_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (3)
  ) u_ctl_dly (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .ce   (pix_ce),
    .data ({active, hs_act, vs_act}),
    .q    (ctl_d)
  );

  assign act_d = ctl_d[2];
  assign hs_d  = ctl_d[1];
  assign vs_d  = ctl_d[0];

`ifdef VGA_TEST_PATTERN_EN
  // Bar index = x*8/H_ACTIVE, taken from x delayed to line up with rgb_in.
  localparam int BW = XW + 3;
  localparam logic [BW-1:0] H_ACT_W = BW'(H_ACTIVE);

  logic [XW-1:0] x_d;
  logic [2:0]    bar_idx;

  vga_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (XW)
  ) u_x_dly (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .ce   (pix_ce),
    .data (req_x),
    .q    (x_d)
  );

  assign bar_idx = 3'({x_d, 3'b000} / H_ACT_W);

  // Pixel source: colour bars replace rgb_in while test_mode is set.
  always_comb begin
    pix_src = rgb_t'(rgb_in);
    if (test_mode) pix_src = bar_color(bar_idx);
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_src = rgb_t'(rgb_in);
`endif

  // Pin register, loaded once per pixel tick.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
    end else if (pix_ce) begin
      VGA_BLANK_N <= act_d;
      VGA_HS      <= ~(hs_d ^ HS_POL);
      VGA_VS      <= ~(vs_d ^ VS_POL);
      {VGA_R, VGA_G, VGA_B} <= act_d ? pix_src : '0;
    end
  end

endmodule
